// File: rtl/imem_server.sv
// Instruction-memory responder: accepts fetch PCs, reads a backdoor-loadable ROM,
// and returns {pc, instr, err} in order after a fixed LATENCY through an output FIFO.
module imem_server #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_3000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_pc,
    input  logic                  flush,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_pc,
    output logic [31:0]           rsp_instr,
    output logic                  rsp_err,
    input  logic                  ld_we,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
);

    localparam int          IW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [32:0] ROM_BYTES = 33'(4) << DEPTH_LOG2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } entry_t;

    function automatic logic addr_fault(input logic [31:0] pc, input logic [31:0] off);
        return (pc[1:0] != 2'b00) || ({1'b0, off} >= ROM_BYTES);
    endfunction

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [31:0] rom [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (ld_we) begin
            rom[ld_addr] <= ld_data;
        end
    end

    // Stage p0: address check and ROM read at the accept edge
    logic                  accept_p0;
    logic [31:0]           off_p0;
    logic [DEPTH_LOG2-1:0] idx_p0;
    entry_t                ent_p0;

    always_comb begin
        off_p0       = req_pc - ADDR_BASE;
        idx_p0       = off_p0[DEPTH_LOG2+1:2];
        ent_p0.pc    = req_pc;
        ent_p0.err   = addr_fault(req_pc, off_p0);
        ent_p0.instr = ent_p0.err ? 32'h0 : rom[idx_p0];
        accept_p0    = req_valid && req_ready;
    end

    // Stages p1..p(LATENCY-1): fixed-delay shift toward the FIFO
    entry_t ent_fifo_in;
    logic   vld_fifo_in;

    generate
        if (LATENCY == 1) begin : g_direct
            assign ent_fifo_in = ent_p0;
            assign vld_fifo_in = accept_p0;
        end else begin : g_pipe
            localparam int NS = LATENCY - 1;
            logic [NS-1:0] vld_pn_q, vld_pn_d;
            entry_t        ent_pn_q [NS];
            entry_t        ent_pn_d [NS];

            always_comb begin
                vld_pn_d    = flush ? '0 : ((vld_pn_q << 1) | NS'(accept_p0));
                ent_pn_d[0] = ent_p0;
                for (int i = 1; i < NS; i++) begin
                    ent_pn_d[i] = ent_pn_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_pn_q <= '0;
                end else begin
                    vld_pn_q <= vld_pn_d;
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < NS; i++) begin
                    ent_pn_q[i] <= ent_pn_d[i];
                end
            end

            assign ent_fifo_in = ent_pn_q[NS-1];
            assign vld_fifo_in = vld_pn_q[NS-1];
        end
    endgenerate

    // Output FIFO and outstanding-request accounting
    entry_t          fifo_mem [FIFO_DEPTH];
    logic [IW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic            push;
    logic            pop;
    entry_t          head;

    assign push = vld_fifo_in && !flush;
    assign pop  = rsp_valid && rsp_ready;
    assign head = fifo_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        outst_d    = outst_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
            outst_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
            outst_d    = outst_q + CW'(accept_p0) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            outst_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            outst_q    <= outst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= ent_fifo_in;
        end
    end

    // The reset term forces req_ready low while reset is held, without waiting for an edge
    assign req_ready = reset && (outst_q < CW'(FIFO_DEPTH)) && !flush;
    assign rsp_valid = (fifo_cnt_q != '0);
    assign rsp_pc    = rsp_valid ? head.pc    : 32'h0;
    assign rsp_instr = rsp_valid ? head.instr : 32'h0;
    assign rsp_err   = rsp_valid ? head.err   : 1'b0;

endmodule

// File: tb/tb_imem_server.sv
// Bench for imem_server: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_imem_server;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 4;
    localparam longint      BASE  = 64'h3000;
    localparam longint      WORDS = 4096;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_pc;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [31:0] ld_data;

    imem_server #(
        .ADDR_BASE (32'h0000_3000),
        .DEPTH_LOG2(12),
        .LATENCY   (LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_pc   (req_pc),
        .flush    (flush),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_pc   (rsp_pc),
        .rsp_instr(rsp_instr),
        .rsp_err  (rsp_err),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted request is an entry visible from cycle 'vis' on
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        int          vis;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        int          cyc;
    } pop_t;

    exp_t        mq[$];
    pop_t        popped[$];
    logic [31:0] rom_m [4096];
    int          cyc = 0;

    function automatic logic model_err(input logic [31:0] pc);
        longint p;
        p = longint'(pc);
        return (pc % 4 != 0) || (p < BASE) || (p >= BASE + 4 * WORDS);
    endfunction

    task automatic model_edge();
        logic acc;
        logic pp;
        exp_t e;
        pp  = (mq.size() > 0) && (mq[0].vis <= cyc) && rsp_ready;
        acc = req_valid && (mq.size() < DEPTH) && !flush;
        cyc++;
        if (flush) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) begin
                e.pc    = req_pc;
                e.err   = model_err(req_pc);
                e.instr = e.err ? 32'h0 : rom_m[(longint'(req_pc) - BASE) / 4];
                e.vis   = cyc + LAT - 1;
                mq.push_back(e);
            end
        end
        if (ld_we) rom_m[ld_addr] = ld_data;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            if (clk) cyc++;
        end else begin
            model_edge();
        end
    end

    // Every-cycle comparison, sampled mid low phase after inputs have settled
    always @(negedge clk) begin
        logic        ev;
        logic        er;
        #2;
        ev = reset && (mq.size() > 0) && (mq[0].vis <= cyc);
        er = reset && (mq.size() < DEPTH) && !flush;
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, ev});
        chk("req_ready", {31'b0, req_ready}, {31'b0, er});
        if (ev) begin
            chk("rsp_pc", rsp_pc, mq[0].pc);
            chk("rsp_instr", rsp_instr, mq[0].instr);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, mq[0].err});
        end else begin
            chk("rsp_pc_idle", rsp_pc, 32'h0);
            chk("rsp_instr_idle", rsp_instr, 32'h0);
            chk("rsp_err_idle", {31'b0, rsp_err}, 32'h0);
        end
        if (rsp_valid && rsp_ready && reset && !flush)
            popped.push_back('{pc: rsp_pc, instr: rsp_instr, err: rsp_err, cyc: cyc});
    end

    task automatic load(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
    endtask

    task automatic issue(input logic [31:0] pc);
        @(negedge clk);
        req_valid = 1'b1; req_pc = pc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] pcs [4];
        logic [31:0] ins [4];
        logic        ers [4];
        int          acc;
        logic [31:0] npc;

        reset = 1'b0; req_valid = 1'b0; req_pc = 32'h0; flush = 1'b0;
        rsp_ready = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < 4096; i++) rom_m[i] = 32'h0;

        @(negedge clk); #1;
        chk("reset_ready", {31'b0, req_ready}, 32'h0);
        chk("reset_valid", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk("release_ready", {31'b0, req_ready}, 32'h1);

        load(12'd0, 32'h3c1d_0000);
        load(12'd1, 32'h0040_0093);
        load(12'd2, 32'h0081_0113);
        load(12'd3, 32'h00c1_8193);
        load(12'd4095, 32'hdead_beef);
        @(negedge clk);
        ld_we = 1'b0;

        // Single fetch: latency and contents
        rsp_ready = 1'b1;
        issue(32'h3000);
        @(negedge clk); req_valid = 1'b0;
        #2 chk("t1_not_yet", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk); #2;
        chk("t1_valid", {31'b0, rsp_valid}, 32'h1);
        chk("t1_pc", rsp_pc, 32'h3000);
        chk("t1_instr", rsp_instr, 32'h3c1d_0000);
        chk("t1_err", {31'b0, rsp_err}, 32'h0);
        @(negedge clk); #2;
        chk("t1_popped", {31'b0, rsp_valid}, 32'h0);

        // Back-to-back stream with no bubbles
        popped.delete();
        pcs = '{32'h3000, 32'h3004, 32'h3008, 32'h300c};
        ins = '{32'h3c1d_0000, 32'h0040_0093, 32'h0081_0113, 32'h00c1_8193};
        for (int i = 0; i < 4; i++) issue(pcs[i]);
        idle(6);
        chk("t2_count", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) begin
            chk("t2_pc", popped[i].pc, pcs[i]);
            chk("t2_instr", popped[i].instr, ins[i]);
            chk("t2_gap", popped[i].cyc - popped[0].cyc, i);
        end

        // Backpressure: exactly FIFO_DEPTH accepts, then drain
        popped.delete();
        rsp_ready = 1'b0;
        acc = 0;
        npc = 32'h3000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_pc = npc;
            #1;
            if (req_ready) begin
                acc++;
                npc += 4;
            end
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        #2;
        chk("t3_accepts", acc, 4);
        chk("t3_full", {31'b0, req_ready}, 32'h0);
        @(negedge clk); #2;
        chk("t3_reopen", {31'b0, req_ready}, 32'h1);
        idle(5);
        chk("t3_count", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) begin
            chk("t3_pc", popped[i].pc, pcs[i]);
            chk("t3_instr", popped[i].instr, ins[i]);
        end

        // Address faults
        popped.delete();
        pcs = '{32'h3002, 32'h2ffc, 32'h7000, 32'h6ffc};
        ins = '{32'h0, 32'h0, 32'h0, 32'hdead_beef};
        ers = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) issue(pcs[i]);
        idle(6);
        chk("t4_count", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) begin
            chk("t4_pc", popped[i].pc, pcs[i]);
            chk("t4_instr", popped[i].instr, ins[i]);
            chk("t4_err", {31'b0, popped[i].err}, {31'b0, ers[i]});
        end

        // Flush discards everything in flight, including a same-cycle pop and request
        popped.delete();
        rsp_ready = 1'b0;
        issue(32'h3000);
        issue(32'h3004);
        issue(32'h3008);
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_pc = 32'h300c; rsp_ready = 1'b1;
        #2 chk("t5_flush_ready", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #2;
        chk("t5_after_ready", {31'b0, req_ready}, 32'h1);
        chk("t5_after_valid", {31'b0, rsp_valid}, 32'h0);
        idle(5);
        chk("t5_nothing", popped.size(), 0);
        issue(32'h3004);
        idle(4);
        chk("t5_count", popped.size(), 1);
        if (popped.size() > 0) begin
            chk("t5_pc", popped[0].pc, 32'h3004);
            chk("t5_instr", popped[0].instr, 32'h0040_0093);
        end

        // Asynchronous reset mid-stream
        popped.delete();
        rsp_ready = 1'b0;
        issue(32'h3000);
        issue(32'h3004);
        @(negedge clk);
        req_valid = 1'b0;
        #1 chk("t6_before", {31'b0, rsp_valid}, 32'h1);
        reset = 1'b0;
        #1;
        chk("t6_async_valid", {31'b0, rsp_valid}, 32'h0);
        chk("t6_async_ready", {31'b0, req_ready}, 32'h0);
        chk("t6_async_pc", rsp_pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; rsp_ready = 1'b1;
        idle(5);
        chk("t6_no_stale", popped.size(), 0);
        issue(32'h3000);
        idle(4);
        chk("t6_count", popped.size(), 1);
        if (popped.size() > 0) begin
            chk("t6_pc", popped[0].pc, 32'h3000);
            chk("t6_instr", popped[0].instr, 32'h3c1d_0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: time limit reached, stimulus did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_server.md
Name: imem_server

Overview:
- Instruction-memory responder: the other end of the fetch path. It accepts PC requests from the Fetch stage and returns the 32-bit instruction word, tagged with its PC, after a fixed configurable latency.
- Contains the instruction ROM, a latency pipeline and an output FIFO, so the memory path can be made multi-cycle without changing the pipeline.
- Flush support discards wrong-path fetches on redirect.

Parameters:
- ADDR_BASE, 32'h0000_3000, byte address of instruction word 0.
- DEPTH_LOG2, 12, log2 of the number of words in the ROM.
- LATENCY, 2, cycles from request accept to response visible; legal range 1..4.
- FIFO_DEPTH, 4, maximum outstanding requests; power of 2, must be >= LATENCY.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  Fetch presents a request.
- req_ready  out  1  request can be accepted this cycle.
- req_pc  in  32  byte address to fetch.
- flush  in  1  synchronous; discard all outstanding requests.
- rsp_valid  out  1  response available at the head of the FIFO.
- rsp_ready  in  1  consumer takes the response.
- rsp_pc  out  32  PC of the head response.
- rsp_instr  out  32  instruction word of the head response.
- rsp_err  out  1  head response is a faulting fetch.
- ld_we  in  1  backdoor ROM write enable.
- ld_addr  in  DEPTH_LOG2  word index to write.
- ld_data  in  32  word to write.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears all pipeline valid bits, FIFO pointers and the outstanding counter.
  - Outputs: rsp_valid=0, rsp_pc=0, rsp_instr=0, rsp_err=0, req_ready=0.
  - ROM contents are not reset.
  - After release, req_ready=1 in the first cycle.
- Accept:
  - A request is accepted on an edge where req_valid && req_ready.
  - req_ready = (outstanding < FIFO_DEPTH) && !flush. It is computed from the registered count only; a same-cycle pop does not raise it.
- Outstanding counter:
  - Counts pipeline entries plus FIFO entries.
  - Increments on accept and decrements on pop (rsp_valid && rsp_ready); both in one cycle leaves it unchanged.
  - It can never exceed FIFO_DEPTH, so the FIFO never overflows.
- Address check (evaluated at accept):
  - off = req_pc - ADDR_BASE, 32-bit wrap-around subtraction.
  - err = (req_pc[1:0] != 0) || (off >= 4*2^DEPTH_LOG2). A pc below ADDR_BASE wraps to a large off and therefore errs.
  - Word index = off[DEPTH_LOG2+1:2].
  - ROM is read at the accept edge; if err, the captured instr is 0.
- Latency:
  - Accepted entries {pc, instr, err} pass through LATENCY-1 register stages, then are written into the FIFO.
  - Accept at edge k gives rsp_valid=1 in the cycle after edge k+LATENCY-1.
  - With LATENCY=1, the entry is written to the FIFO at the accept edge.
  - Back-to-back accepts with rsp_ready=1 give one response per cycle, with no bubbles.
- Response:
  - rsp_valid = FIFO not empty. Responses leave in strict accept order.
  - While rsp_valid && !rsp_ready, rsp_pc, rsp_instr and rsp_err hold stable.
  - When rsp_valid=0, rsp_pc, rsp_instr and rsp_err are 0.
- Flush:
  - At the flush edge: clear pipeline valids, empty the FIFO, set outstanding=0.
  - A request presented in the flush cycle is not accepted.
  - A pop in the flush cycle is discarded.
  - req_ready=1 in the next cycle.
- Backdoor load:
  - ld_we writes ld_data at ld_addr on the edge.
  - If an accept reads the same index on the same edge, it returns the old word.
  - Loads are independent of flush and of the handshake.
- Reset mid-operation: all in-flight and queued responses are lost, with no stale response after release.

Test Plan:
- Load index 0 = 32'h3c1d0000, LATENCY=2. Req pc 32'h3000 at edge 1, rsp_ready=1 -> after edge 2: rsp_valid=1, rsp_pc=32'h3000, rsp_instr=32'h3c1d0000, rsp_err=0. Popped at edge 3.
- Requests 3000/3004/3008/300c on consecutive edges, rsp_ready=1 -> four consecutive rsp_valid cycles, in order, correct words, no gaps.
- rsp_ready=0, req_valid held -> exactly 4 accepts, then req_ready=0. Raise rsp_ready -> drains 4 responses in order; req_ready=1 the cycle after the first pop.
- pc 32'h3002 -> err=1, instr=0. pc 32'h2ffc -> err=1. pc 32'h7000 -> err=1. pc 32'h6ffc -> err=0 with the loaded word.
- 3 outstanding, then flush=1 with req_valid=1 -> req_ready=0 that cycle, no responses ever appear. Next request 32'h3004 returns normally after LATENCY.
- Assert reset mid-stream with 2 outstanding -> rsp_valid=0 immediately, before the next edge. After release, no responses appear; re-fetching 32'h3000 still returns 32'h3c1d0000 (ROM preserved).
